// File: rtl/store_merge_pkg.sv
// Shared size/state encodings and byte-lane helpers for the read-modify-write store unit.
package store_merge_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Widest supported memory word is 64 bits: 8 lanes, 3 offset bits.
    localparam int MAX_LANES = 8;
    localparam int MAX_OFF_W = 3;

    // Byte enables for a store of 1<<size bytes starting at lane 'offset',
    // clipped to the number of lanes actually present.
    function automatic logic [MAX_LANES-1:0] lane_mask(
        input logic [1:0]           size,
        input logic [MAX_OFF_W-1:0] offset,
        input int                   lanes
    );
        logic [MAX_LANES-1:0] mask;
        int nbytes;
        int first;
        nbytes = 1 << size;
        first  = int'(offset);
        mask   = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes && i >= first && i < first + nbytes) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Natural alignment: the offset must be a multiple of the access size.
    function automatic logic is_aligned(
        input logic [1:0]           size,
        input logic [MAX_OFF_W-1:0] offset
    );
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (offset[0] == 1'b0);
            SZ_WORD: ok = (offset[1:0] == 2'b00);
            default: ok = (offset == '0);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: masked lanes take the shifted store data,
// the remaining lanes keep the bytes read from memory.
module byte_lane_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0]         mask,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [DATA_W-1:0]           req_data,
    input  logic [DATA_W-1:0]           rd_data,
    output logic [DATA_W-1:0]           merged
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] shifted;

    // Move register byte 0 onto lane 'offset', then select per lane.
    always_comb begin
        shifted = req_data << {offset, 3'b000};
        merged  = '0;
        for (int i = 0; i < LANES; i++) begin
            merged[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : rd_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/store_merge_rmw.sv
// Read-modify-write store unit: reads the aligned memory word, merges the
// store bytes into the addressed lanes and writes the word back. Full-width
// stores may skip the read; misaligned requests and read timeouts are flagged.
module store_merge_rmw
    import store_merge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BYPASS_FULL = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    input  logic [1:0]        ReqSize,
    output logic [ADDR_W-1:0] MemAdr,
    output logic              MemRdEn,
    input  logic              MemRdValid,
    input  logic [DATA_W-1:0] MemRdData,
    output logic              MemWrEn,
    output logic [DATA_W-1:0] MemWrData,
    input  logic              MemWrReady,
    output logic              Done,
    output logic              Misaligned,
    output logic              Timeout
);

    localparam int         LANES     = DATA_W / 8;
    localparam int         LANE_W    = $clog2(LANES);
    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    // Size code of a store covering the whole word (word for 32, dword for 64).
    localparam logic [1:0] FULL_SIZE = 2'(LANE_W);

    state_e             state;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic               rd_en_d;
    logic               wr_en_d;
    logic               done_d;
    logic               mis_d;
    logic               to_d;
    logic [ADDR_W-1:0]  adr_d;
    logic [DATA_W-1:0]  wdata_d;

    logic [LANE_W-1:0]    req_off;
    logic [MAX_OFF_W-1:0] req_off_ext;
    logic [MAX_LANES-1:0] req_mask_full;
    logic [LANES-1:0]     req_mask;
    logic                 req_misaligned;
    logic                 req_full;
    logic [ADDR_W-1:0]    req_aligned;

    logic                 cap_load;
    logic [DATA_W-1:0]    cap_data;
    logic [LANE_W-1:0]    cap_off;
    logic [LANES-1:0]     cap_mask;
    logic [DATA_W-1:0]    merged;

    assign ReqReady = (state == ST_IDLE);

    // Decode the incoming request: lane offset, byte enables, alignment, full-width.
    always_comb begin
        req_off                     = ReqAddr[LANE_W-1:0];
        req_off_ext                 = '0;
        req_off_ext[LANE_W-1:0]     = req_off;
        req_mask_full               = lane_mask(ReqSize, req_off_ext, LANES);
        req_mask                    = req_mask_full[LANES-1:0];
        req_misaligned              = (int'(ReqSize) > LANE_W) || !is_aligned(ReqSize, req_off_ext);
        req_full                    = (ReqSize == FULL_SIZE);
        req_aligned                 = ReqAddr;
        req_aligned[LANE_W-1:0]     = '0;
    end

    // Hold the accepted request for the merge; data-only, so no reset needed.
    always_ff @(posedge Clk) begin
        if (cap_load) begin
            cap_data <= ReqData;
            cap_off  <= req_off;
            cap_mask <= req_mask;
        end
    end

    byte_lane_merge #(
        .DATA_W(DATA_W)
    ) u_merge (
        .mask    (cap_mask),
        .offset  (cap_off),
        .req_data(cap_data),
        .rd_data (MemRdData),
        .merged  (merged)
    );

    // Next-state and next-output logic; every output is registered on entry to its state.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rd_en_d  = 1'b0;
        wr_en_d  = MemWrEn;
        done_d   = 1'b0;
        mis_d    = 1'b0;
        to_d     = 1'b0;
        adr_d    = MemAdr;
        wdata_d  = MemWrData;
        cap_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ReqValid) begin
                    cap_load = 1'b1;
                    if (req_misaligned) begin
                        state_d = ST_ERR;
                        mis_d   = 1'b1;
                    end else if (BYPASS_FULL != 0 && req_full) begin
                        state_d = ST_WRITE;
                        wr_en_d = 1'b1;
                        adr_d   = req_aligned;
                        wdata_d = ReqData;
                    end else begin
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
                        adr_d   = req_aligned;
                        cnt_d   = '0;
                    end
                end
            end
            ST_READ: begin
                // The counter measures cycles since the read strobe.
                state_d = ST_WAIT;
                cnt_d   = cnt + 1'b1;
            end
            ST_WAIT: begin
                // Data arriving on the expiry cycle still wins over the timeout.
                if (MemRdValid) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                    wdata_d = merged;
                end else if (int'(cnt) >= TIMEOUT - 1) begin
                    state_d = ST_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_WRITE: begin
                if (MemWrReady) begin
                    state_d = ST_IDLE;
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            MemRdEn    <= 1'b0;
            MemWrEn    <= 1'b0;
            Done       <= 1'b0;
            Misaligned <= 1'b0;
            Timeout    <= 1'b0;
            MemAdr     <= '0;
            MemWrData  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            MemRdEn    <= rd_en_d;
            MemWrEn    <= wr_en_d;
            Done       <= done_d;
            Misaligned <= mis_d;
            Timeout    <= to_d;
            MemAdr     <= adr_d;
            MemWrData  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: a 32-bit and a 64-bit instance share stimulus,
// and sel64 chooses which one is driven and observed.
module tb_store_merge_rmw;

    localparam int K_MIS = 0;
    localparam int K_BYP = 1;
    localparam int K_RMW = 2;

    // Strobe vector order: {MemRdEn, MemWrEn, Done, Misaligned, Timeout}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_RD   = 5'b10000;
    localparam logic [4:0] S_WR   = 5'b01000;
    localparam logic [4:0] S_DN   = 5'b00100;
    localparam logic [4:0] S_MIS  = 5'b00010;
    localparam logic [4:0] S_TO   = 5'b00001;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        sel64;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_size;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        wr_ready;

    logic        rr32, re32, we32, dn32, mis32, to32;
    logic [31:0] adr32, wd32;
    logic        rr64, re64, we64, dn64, mis64, to64;
    logic [31:0] adr64;
    logic [63:0] wd64;

    logic        ready;
    logic [4:0]  strobes;
    logic [31:0] mem_adr;
    logic [63:0] wr_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .BYPASS_FULL(1), .TIMEOUT(8)) dut32 (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(req_valid && !sel64), .ReqReady(rr32),
        .ReqAddr(req_addr), .ReqData(req_data[31:0]), .ReqSize(req_size),
        .MemAdr(adr32), .MemRdEn(re32),
        .MemRdValid(rd_valid && !sel64), .MemRdData(rd_data[31:0]),
        .MemWrEn(we32), .MemWrData(wd32), .MemWrReady(wr_ready && !sel64),
        .Done(dn32), .Misaligned(mis32), .Timeout(to32)
    );

    store_merge_rmw #(.DATA_W(64), .ADDR_W(32), .BYPASS_FULL(1), .TIMEOUT(8)) dut64 (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(req_valid && sel64), .ReqReady(rr64),
        .ReqAddr(req_addr), .ReqData(req_data), .ReqSize(req_size),
        .MemAdr(adr64), .MemRdEn(re64),
        .MemRdValid(rd_valid && sel64), .MemRdData(rd_data),
        .MemWrEn(we64), .MemWrData(wd64), .MemWrReady(wr_ready && sel64),
        .Done(dn64), .Misaligned(mis64), .Timeout(to64)
    );

    assign ready   = sel64 ? rr64 : rr32;
    assign strobes = sel64 ? {re64, we64, dn64, mis64, to64} : {re32, we32, dn32, mis32, to32};
    assign mem_adr = sel64 ? adr64 : adr32;
    assign wr_data = sel64 ? wd64 : {32'h0, wd32};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: classify a request from the size/offset rules.
    function automatic int model_kind(input logic s64, input logic [31:0] addr, input logic [1:0] size);
        int w;
        int n;
        int off;
        w   = s64 ? 8 : 4;
        n   = 1 << size;
        off = int'(addr[2:0]) % w;
        if (n > w || (off % n) != 0) return K_MIS;
        if (n == w) return K_BYP;
        return K_RMW;
    endfunction

    // Reference: word written back, built from a byte-enable mask with plain arithmetic.
    function automatic logic [63:0] model_wdata(input logic s64, input logic [31:0] addr,
                                                input logic [63:0] data, input logic [1:0] size,
                                                input logic [63:0] mem);
        int w;
        int n;
        int off;
        logic [63:0] wmask;
        logic [63:0] m;
        w     = s64 ? 8 : 4;
        n     = 1 << size;
        off   = int'(addr[2:0]) % w;
        wmask = s64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (n >= w) return data & wmask;
        m = ((64'd1 << (8 * n)) - 64'd1) << (8 * off);
        return ((mem & ~m) | ((data << (8 * off)) & m)) & wmask;
    endfunction

    // One complete store transaction with fixed read latency and write back-pressure.
    task automatic run_store(input logic s64, input logic [31:0] addr, input logic [63:0] data,
                             input logic [1:0] size, input logic [63:0] mem, input int lat,
                             input int rdy, input int kind, input logic [63:0] exp_wd,
                             input string name);
        int w;
        logic [31:0] exp_adr;
        w       = s64 ? 8 : 4;
        exp_adr = addr & ~(32'(w - 1));
        sel64     = s64;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        req_valid = 1'b1;
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_before: got %b expected 1", name, ready);
        end
        tick();
        req_valid = 1'b0;
        req_data  = {$urandom, $urandom};
        if (kind == K_MIS) begin
            tests_run++;
            if ({ready, strobes} !== {1'b0, S_MIS}) begin
                tests_failed++;
                $display("FAIL %s mis_pulse: got rdy=%b strobes=%b expected rdy=0 strobes=%b", name, ready, strobes, S_MIS);
            end
            tick();
            tests_run++;
            if ({ready, strobes} !== {1'b1, S_NONE}) begin
                tests_failed++;
                $display("FAIL %s mis_end: got rdy=%b strobes=%b expected rdy=1 strobes=%b", name, ready, strobes, S_NONE);
            end
            return;
        end
        if (kind == K_RMW) begin
            tests_run++;
            if (strobes !== S_RD || mem_adr !== exp_adr) begin
                tests_failed++;
                $display("FAIL %s read: got strobes=%b adr=%h expected strobes=%b adr=%h", name, strobes, mem_adr, S_RD, exp_adr);
            end
            tick();
            for (int i = 1; i < lat; i++) begin
                tests_run++;
                if ({ready, strobes} !== {1'b0, S_NONE}) begin
                    tests_failed++;
                    $display("FAIL %s wait: got rdy=%b strobes=%b expected rdy=0 strobes=%b", name, ready, strobes, S_NONE);
                end
                req_valid = 1'b1;
                req_data  = {$urandom, $urandom};
                tick();
            end
            req_valid = 1'b0;
            rd_valid  = 1'b1;
            rd_data   = mem;
            tick();
            rd_valid  = 1'b0;
            rd_data   = {$urandom, $urandom};
        end
        tests_run++;
        if (strobes !== S_WR || wr_data !== exp_wd || mem_adr !== exp_adr) begin
            tests_failed++;
            $display("FAIL %s write: got strobes=%b data=%h adr=%h expected strobes=%b data=%h adr=%h",
                     name, strobes, wr_data, mem_adr, S_WR, exp_wd, exp_adr);
        end
        for (int i = 0; i < rdy; i++) begin
            rd_valid  = 1'b1;
            req_valid = 1'b1;
            tick();
            tests_run++;
            if (strobes !== S_WR || wr_data !== exp_wd || mem_adr !== exp_adr) begin
                tests_failed++;
                $display("FAIL %s hold: got strobes=%b data=%h adr=%h expected strobes=%b data=%h adr=%h",
                         name, strobes, wr_data, mem_adr, S_WR, exp_wd, exp_adr);
            end
        end
        rd_valid  = 1'b0;
        req_valid = 1'b0;
        wr_ready  = 1'b1;
        tick();
        wr_ready  = 1'b0;
        tests_run++;
        if ({ready, strobes} !== {1'b1, S_DN}) begin
            tests_failed++;
            $display("FAIL %s done: got rdy=%b strobes=%b expected rdy=1 strobes=%b", name, ready, strobes, S_DN);
        end
        tick();
        tests_run++;
        if (strobes !== S_NONE) begin
            tests_failed++;
            $display("FAIL %s after_done: got strobes=%b expected %b", name, strobes, S_NONE);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b1;
        #2;
        Rst_n = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            tests_run++;
            if ({ready, strobes, mem_adr, wr_data} !== {1'b1, S_NONE, 32'h0, 64'h0}) begin
                tests_failed++;
                $display("FAIL reset_state sel64=%0d: got rdy=%b strobes=%b adr=%h data=%h expected rdy=1 all zero",
                         s, ready, strobes, mem_adr, wr_data);
            end
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_subword();
        run_store(1'b0, 32'h1001, 64'h0000_FFAC, 2'd0, 64'h0ACF_FB19, 2, 1, K_RMW, 64'h0ACF_AC19, "sb_off1");
        run_store(1'b0, 32'h1002, 64'h0000_FFAC, 2'd1, 64'h0ACF_FB19, 2, 1, K_RMW, 64'hFFAC_FB19, "sh_off2");
        run_store(1'b0, 32'h1003, 64'h0000_FFAC, 2'd0, 64'h0ACF_FB19, 1, 0, K_RMW, 64'hACCF_FB19, "sb_off3");
    endtask

    task automatic test_bypass();
        run_store(1'b0, 32'h2000, 64'h0000_FFAC, 2'd2, 64'h0, 0, 3, K_BYP, 64'h0000_FFAC, "sw_bypass_stall");
        run_store(1'b0, 32'h2004, 64'h1234_5678, 2'd2, 64'h0, 0, 0, K_BYP, 64'h1234_5678, "sw_bypass_fast");
    endtask

    task automatic test_misaligned();
        run_store(1'b0, 32'h1001, 64'h0000_FFAC, 2'd1, 64'h0, 0, 0, K_MIS, 64'h0, "sh_misaligned");
        run_store(1'b0, 32'h1000, 64'h0000_FFAC, 2'd3, 64'h0, 0, 0, K_MIS, 64'h0, "sd_on_32bit");
        run_store(1'b1, 32'h1004, 64'h0000_FFAC, 2'd3, 64'h0, 0, 0, K_MIS, 64'h0, "sd_off4_64");
    endtask

    task automatic test_timeout(input logic valid_on_expiry);
        sel64     = 1'b0;
        req_addr  = 32'h3001;
        req_data  = 64'h0000_FFAC;
        req_size  = 2'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (strobes !== S_RD) begin
            tests_failed++;
            $display("FAIL timeout_read: got strobes=%b expected %b", strobes, S_RD);
        end
        for (int k = 1; k <= 8; k++) begin
            logic [4:0] exp_s;
            if (valid_on_expiry && k == 8) begin
                rd_valid = 1'b1;
                rd_data  = 64'h0ACF_FB19;
            end
            tick();
            rd_valid = 1'b0;
            exp_s = (k == 8) ? (valid_on_expiry ? S_WR : S_TO) : S_NONE;
            tests_run++;
            if (strobes !== exp_s) begin
                tests_failed++;
                $display("FAIL timeout_cycle%0d v=%0d: got strobes=%b expected %b", k, valid_on_expiry, strobes, exp_s);
            end
        end
        if (valid_on_expiry) begin
            tests_run++;
            if (wr_data !== 64'h0ACF_AC19) begin
                tests_failed++;
                $display("FAIL timeout_late_data: got %h expected %h", wr_data, 64'h0ACF_AC19);
            end
            wr_ready = 1'b1;
            tick();
            wr_ready = 1'b0;
            tests_run++;
            if (strobes !== S_DN) begin
                tests_failed++;
                $display("FAIL timeout_late_done: got strobes=%b expected %b", strobes, S_DN);
            end
        end else begin
            tests_run++;
            if (ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL timeout_ready: got %b expected 1", ready);
            end
        end
        tick();
        tests_run++;
        if (strobes !== S_NONE) begin
            tests_failed++;
            $display("FAIL timeout_end: got strobes=%b expected %b", strobes, S_NONE);
        end
    endtask

    task automatic test_dword64();
        run_store(1'b1, 32'h5005, 64'h0000_00AC, 2'd0, 64'h1122_3344_5566_7788, 3, 2, K_RMW,
                  64'h1122_AC44_5566_7788, "sb64_off5");
        run_store(1'b1, 32'h5004, 64'hDEAD_BEEF, 2'd2, 64'h1122_3344_5566_7788, 1, 0, K_RMW,
                  64'hDEAD_BEEF_5566_7788, "sw64_off4");
        run_store(1'b1, 32'h5008, 64'hCAFE_F00D_0123_4567, 2'd3, 64'h0, 0, 1, K_BYP,
                  64'hCAFE_F00D_0123_4567, "sd64_bypass");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        s64;
            logic [31:0] addr;
            logic [63:0] data;
            logic [63:0] mem;
            logic [1:0]  size;
            int          kind;
            s64  = 1'($urandom_range(0, 1));
            addr = $urandom;
            data = {$urandom, $urandom};
            mem  = {$urandom, $urandom};
            if (!s64) mem[63:32] = 32'h0;
            size = 2'($urandom_range(0, 3));
            kind = model_kind(s64, addr, size);
            run_store(s64, addr, data, size, mem, $urandom_range(1, 5), $urandom_range(0, 3), kind,
                      model_wdata(s64, addr, data, size, mem), "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        sel64     = 1'b1;
        req_addr  = 32'h4005;
        req_data  = 64'hAC;
        req_size  = 2'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        Rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ready, strobes, mem_adr, wr_data} !== {1'b1, S_NONE, 32'h0, 64'h0}) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got rdy=%b strobes=%b adr=%h data=%h expected rdy=1 all zero",
                     ready, strobes, mem_adr, wr_data);
        end
        rd_valid = 1'b1;
        rd_data  = 64'h1122_3344_5566_7788;
        tick();
        rd_valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        tests_run++;
        if ({ready, strobes} !== {1'b1, S_NONE}) begin
            tests_failed++;
            $display("FAIL reset_no_write: got rdy=%b strobes=%b expected rdy=1 strobes=%b", ready, strobes, S_NONE);
        end
    endtask

    initial begin
        sel64     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        wr_ready  = 1'b0;
        test_reset();
        test_subword();
        test_bypass();
        test_misaligned();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_dword64();
        test_random();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
Parametrised read-modify-write store unit; successor to the combinational sub-word store mask.
Accepts byte/half/word/dword store requests and reads the aligned memory word. Merges the register bytes into the addressed lanes, then writes the word back.
Sits between the MEM-stage store path and the data memory port. Adds a handshake, misalignment trapping, a full-width bypass and a read timeout.

Parameters:
DATA_W, 32, memory word width in bits; 32 or 64
ADDR_W, 32, byte address width
BYPASS_FULL, 1, when 1 a full-width store skips the read phase
TIMEOUT, 16, max cycles waiting for MemRdValid before abort; must be >= 1

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
ReqValid  in  1  store request present
ReqReady  out  1  unit idle and able to accept
ReqAddr  in  ADDR_W  byte address of store
ReqData  in  DATA_W  register data, right-justified
ReqSize  in  2  0=byte, 1=half, 2=word, 3=dword (3 legal only when DATA_W=64)
MemAdr  out  ADDR_W  word-aligned address (low LANE_W bits zero, LANE_W=log2(DATA_W/8))
MemRdEn  out  1  one-cycle read strobe
MemRdValid  in  1  read data valid
MemRdData  in  DATA_W  read data
MemWrEn  out  1  write request, held until accepted
MemWrData  out  DATA_W  merged word
MemWrReady  in  1  memory accepts write this cycle
Done  out  1  one-cycle pulse: write accepted
Misaligned  out  1  one-cycle pulse: request rejected
Timeout  out  1  one-cycle pulse: read aborted

Behaviour:
- Reset (Rst_n=0, async): state IDLE; MemRdEn, MemWrEn, Done, Misaligned, Timeout = 0; MemAdr = 0; MemWrData = 0; wait counter = 0.
- ReqReady = (state==IDLE), combinational; therefore 1 during reset.
- Registered outputs throughout.
- Byte lanes are little-endian. Offset = ReqAddr[LANE_W-1:0]; nbytes = 1<<ReqSize.
- Lane i takes ReqData byte (i-offset) when offset <= i < offset+nbytes; otherwise it takes MemRdData byte i.
- States: IDLE, READ, WAIT, WRITE, ERR.
- IDLE, on ReqValid:
  - Capture addr, data and size.
  - Misaligned if offset mod nbytes != 0, or ReqSize=3 with DATA_W=32 -> ERR.
  - Else if nbytes==DATA_W/8 and BYPASS_FULL -> WRITE with MemWrData=ReqData.
  - Else -> READ.
- READ: MemRdEn=1 for exactly one cycle; MemAdr=aligned address; clear counter; -> WAIT.
- WAIT:
  - On MemRdValid, register merged data into MemWrData -> WRITE.
  - Else increment counter. When counter reaches TIMEOUT-1 without valid, pulse Timeout -> IDLE; no write issued.
  - MemRdValid in the same cycle as expiry: data wins and no Timeout is raised.
- WRITE: MemWrEn=1, MemAdr and MemWrData stable until MemWrReady. The cycle after acceptance: MemWrEn=0, Done=1 for one cycle -> IDLE.
- ERR: Misaligned=1 for one cycle; no MemRdEn or MemWrEn -> IDLE.
- Latency: request accepted at cycle N.
  - Sub-word path: MemRdEn at N+1. Read data at cycle R (>=N+2) gives MemWrEn at R+1. Accepted write at cycle W gives Done at W+1.
  - Bypass path: MemWrEn at N+1; Done at N+2 if MemWrReady=1.
- ReqValid while not IDLE: ignored, ReqData not sampled. MemRdValid outside WAIT: ignored.
- Reset asserted mid-operation: immediate abort to reset values; any pending write is dropped.

Decomposition:
- Package store_merge_pkg:
  - size encodings (SZ_BYTE..SZ_DWORD)
  - state enum
  - function lane_mask(size, offset, DATA_W/8) returning a byte-enable vector
  - function is_aligned(size, offset)
- Sub-module byte_lane_merge (combinational, parameter DATA_W): inputs mask, offset, ReqData, MemRdData; output merged word. Unit-testable standalone.

Test Plan:
- DATA_W=32, ReqData=0x0000FFAC, ReqSize=0, ReqAddr=0x1001, MemRdData=0x0ACFFB19 with 2-cycle read latency -> MemRdEn once with MemAdr=0x1000; MemWrData=0x0ACFAC19; Done one cycle after MemWrReady.
- ReqSize=1, ReqAddr=0x1002, same data -> MemWrData=0xFFACFB19; ReqSize=0 at offset 3 -> 0xAC CFFB19 (0xACCFFB19).
- ReqSize=2, ReqAddr=0x2000, BYPASS_FULL=1 -> no MemRdEn; MemWrEn at N+1 with 0x0000FFAC; with MemWrReady low 3 cycles, data is held and Done follows acceptance.
- ReqSize=1, ReqAddr=0x1001 -> Misaligned pulse, no memory strobes, ReqReady back high after 2 cycles; repeat with ReqSize=3 at DATA_W=32.
- TIMEOUT=8, MemRdValid never asserted -> Timeout pulse 8 cycles after MemRdEn, no MemWrEn. Repeat with valid on the expiry cycle -> write proceeds, no Timeout.
- DATA_W=64, sb 0xAC at offset 5 over MemRdData=0x1122334455667788 -> 0x1122AC4455667788. Drop Rst_n during WAIT -> all outputs 0 immediately, ReqReady=1.
